// File: rtl/fp16_pkg.sv
// Shared FP16 field layout, result-flag encoding and a classification helper
// used by the FP16 result collector.
package fp16_pkg;

    localparam int FP16_W = 16;
    localparam int EXP_W  = 5;
    localparam int MAN_W  = 10;
    localparam logic [EXP_W-1:0] EXP_MAX = 5'd31;

    localparam int MAN_LSB  = 0;
    localparam int MAN_MSB  = MAN_W - 1;
    localparam int EXP_LSB  = MAN_W;
    localparam int EXP_MSB  = EXP_LSB + EXP_W - 1;
    localparam int SIGN_BIT = FP16_W - 1;

    localparam int FLG_ZERO = 0;
    localparam int FLG_INF  = 1;
    localparam int FLG_NAN  = 2;
    localparam int FLG_W    = 3;

    typedef logic [FP16_W-1:0] fp16_t;
    typedef logic [FLG_W-1:0]  fp16_flags_t;

    // Zero ignores the sign, so both +0 and -0 report as zero.
    function automatic fp16_flags_t fp16_classify(input fp16_t c);
        fp16_flags_t f;
        logic        expAllOnes;
        logic        manZero;
        expAllOnes  = (c[EXP_MSB:EXP_LSB] == EXP_MAX);
        manZero     = (c[MAN_MSB:MAN_LSB] == '0);
        f           = '0;
        f[FLG_ZERO] = (c[SIGN_BIT-1:0] == '0);
        f[FLG_INF]  = expAllOnes && manZero;
        f[FLG_NAN]  = expAllOnes && !manZero;
        return f;
    endfunction

endpackage

// File: rtl/fp16_result_collector_if.sv
// Operand-credit and result ready/valid bundle between the adder side,
// the result collector and its consumer.
interface fp16_result_collector_if;
    import fp16_pkg::*;

    logic        in_valid;
    logic        issue_ready;
    fp16_t       C;
    logic        out_valid;
    logic        out_ready;
    fp16_t       out_data;
    fp16_flags_t out_flags;
    logic        drop_err;

    modport master (
        output in_valid, C, out_ready,
        input  issue_ready, out_valid, out_data, out_flags, drop_err
    );

    modport slave (
        input  in_valid, C, out_ready,
        output issue_ready, out_valid, out_data, out_flags, drop_err
    );

endinterface

// File: rtl/fp_sync_fifo.sv
// Synchronous FIFO with a registered head: the oldest entry is always held in
// head_q so the output never depends combinationally on the RAM read.
module fp_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] head_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    rd_next;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             pop;

    assign pop = rd_en_i && (count_q != '0);

    // After a pop the new head is the next stored entry, or the entry being
    // written this cycle when it is the only one left.
    always_comb begin
        rd_next  = rd_ptr_q + 1'b1;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;

        if (wr_en_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d = rd_next;

        case ({wr_en_i, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (pop) begin
            if (count_q > (AW+1)'(1)) head_d = mem_q[rd_next];
            else if (wr_en_i)         head_d = wr_data_i;
        end else if ((count_q == '0) && wr_en_i) begin
            head_d = wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign head_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/fp16_result_collector.sv
// Collects results of the LAT-stage FP16 adder into a FIFO with credit-based
// issue control. Define FPCOL_CLASSIFY_EN to store zero/inf/NaN flags per entry.
module fp16_result_collector
    import fp16_pkg::*;
#(
    parameter int LAT   = 4,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input logic                    clk,
    input logic                    rst,
    fp16_result_collector_if.slave bus
);

`ifdef FPCOL_CLASSIFY_EN
    localparam int ENTRY_W = FP16_W + FLG_W;
`else
    localparam int ENTRY_W = FP16_W;
`endif

    logic [LAT-1:0]     vld_sr_q, vld_sr_d;
    logic               drop_err_q, drop_err_d;
    logic               res_valid;
    logic               pop;
    logic               push;
    logic               full;
    logic [AW:0]        fifo_count;
    logic [AW+1:0]      inflight;
    logic [AW+1:0]      credit_sum;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head;

    // Every operand pair marked valid is tracked, even one issued without credit.
    always_comb begin
        vld_sr_d[0] = bus.in_valid;
        for (int i = 1; i < LAT; i++) vld_sr_d[i] = vld_sr_q[i-1];
    end

    assign res_valid = vld_sr_q[LAT-1];

    // Pops are credited one cycle late because the credit uses the registered count.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) inflight = inflight + (AW+2)'(vld_sr_q[i]);
        credit_sum = {1'b0, fifo_count} + inflight;
    end

    assign bus.issue_ready = credit_sum < (AW+2)'(DEPTH);

    assign full       = (fifo_count == (AW+1)'(DEPTH));
    assign pop        = bus.out_valid && bus.out_ready;
    assign push       = res_valid && (!full || pop);
    assign drop_err_d = drop_err_q || (res_valid && full && !pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr_q   <= '0;
            drop_err_q <= 1'b0;
        end else begin
            vld_sr_q   <= vld_sr_d;
            drop_err_q <= drop_err_d;
        end
    end

`ifdef FPCOL_CLASSIFY_EN
    assign wr_entry      = {fp16_classify(bus.C), bus.C};
    assign bus.out_flags = head[FP16_W +: FLG_W];
`else
    assign wr_entry      = bus.C;
    assign bus.out_flags = '0;
`endif

    fp_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (push),
        .wr_data_i (wr_entry),
        .rd_en_i   (pop),
        .head_o    (head),
        .count_o   (fifo_count)
    );

    assign bus.out_valid = (fifo_count != '0);
    assign bus.out_data  = head[FP16_W-1:0];
    assign bus.drop_err  = drop_err_q;

endmodule

// File: tb/tb_fp16_result_collector.sv
// Directed testbench for fp16_result_collector: emulates the adder pipeline
// and checks every cycle against a queue-based scoreboard.
module tb_fp16_result_collector;
    import fp16_pkg::*;

    localparam int LAT   = 4;
    localparam int DEPTH = 8;

`ifdef FPCOL_CLASSIFY_EN
    localparam bit CLS_EN = 1'b1;
`else
    localparam bit CLS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    fp16_result_collector_if bus ();

    fp16_result_collector #(
        .LAT   (LAT),
        .DEPTH (DEPTH),
        .AW    (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          testCount = 0;
    int          failCount = 0;
    logic [18:0] expQ[$];
    logic [LAT-1:0] mVld = '0;
    logic [15:0] mDat [LAT];
    logic        mDrop = 1'b0;

    // Reference classification written directly from the flag definitions.
    function automatic logic [2:0] refFlags(input logic [15:0] c);
        logic [2:0] f;
        f = 3'b000;
        if (c[14:0] == 15'd0)      f = 3'b001;
        else if (c[14:10] == 5'h1f) f = (c[9:0] == 10'd0) ? 3'b010 : 3'b100;
        return CLS_EN ? f : 3'b000;
    endfunction

    task automatic checkOutput(input string name, input logic [18:0] obs, input logic [18:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic applyStimulus(input logic r, input logic inV, input logic [15:0] cIssue,
                                 input logic outR, input bit doCheck);
        int   inflight;
        bit   popNow;
        bit   wasFull;
        rst           = r;
        bus.in_valid  = inV;
        bus.out_ready = outR;
        bus.C         = mDat[LAT-1];
        #1;
        if (doCheck) begin
            inflight = 0;
            for (int i = 0; i < LAT; i++) inflight += int'(mVld[i]);
            checkOutput("out_valid", 19'(bus.out_valid), 19'(expQ.size() != 0));
            if (expQ.size() != 0) begin
                checkOutput("out_data", 19'(bus.out_data), 19'(expQ[0][15:0]));
                checkOutput("out_flags", 19'(bus.out_flags), 19'(expQ[0][18:16]));
            end
            checkOutput("issue_ready", 19'(bus.issue_ready), 19'((expQ.size() + inflight) < DEPTH));
            checkOutput("drop_err", 19'(bus.drop_err), 19'(mDrop));
        end
        popNow  = outR && (expQ.size() != 0);
        wasFull = (expQ.size() == DEPTH);
        if (r) begin
            expQ.delete();
            mVld  = '0;
            mDrop = 1'b0;
            for (int i = 0; i < LAT; i++) mDat[i] = 16'h0000;
        end else begin
            if (popNow) void'(expQ.pop_front());
            if (mVld[LAT-1]) begin
                if (wasFull && !popNow) mDrop = 1'b1;
                else expQ.push_back({refFlags(mDat[LAT-1]), mDat[LAT-1]});
            end
            for (int i = LAT-1; i > 0; i--) begin
                mVld[i] = mVld[i-1];
                mDat[i] = mDat[i-1];
            end
            mVld[0] = inV;
            mDat[0] = inV ? cIssue : 16'hDEAD;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < LAT; i++) mDat[i] = 16'h0000;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.C         = 16'h0000;

        $display("[TB] reset");
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        checkOutput("reset out_valid", 19'(bus.out_valid), 19'd0);
        checkOutput("reset out_data", 19'(bus.out_data), 19'd0);
        checkOutput("reset out_flags", 19'(bus.out_flags), 19'd0);
        checkOutput("reset drop_err", 19'(bus.drop_err), 19'd0);
        checkOutput("reset issue_ready", 19'(bus.issue_ready), 19'd1);

        $display("[TB] single issue latency");
        applyStimulus(1'b0, 1'b1, 16'h4200, 1'b0, 1'b1);
        for (int c = 1; c <= 4; c++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        checkOutput("single out_valid", 19'(bus.out_valid), 19'd1);
        checkOutput("single out_data", 19'(bus.out_data), 19'h04200);
        checkOutput("single out_flags", 19'(bus.out_flags), 19'd0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        checkOutput("single popped", 19'(bus.out_valid), 19'd0);

        $display("[TB] back-to-back fill");
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 16'h3C00 + 16'(i), 1'b0, 1'b1);
        checkOutput("credit exhausted", 19'(bus.issue_ready), 19'd0);
        for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        checkOutput("fill head", 19'(bus.out_data), 19'h03C00);
        checkOutput("fill no drop", 19'(bus.drop_err), 19'd0);
        for (int c = 0; c < 9; c++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);

        $display("[TB] forced overflow");
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, 16'h5000 + 16'(i), 1'b0, 1'b1);
        for (int c = 0; c < 5; c++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        checkOutput("overflow drop_err", 19'(bus.drop_err), 19'd1);
        checkOutput("overflow head", 19'(bus.out_data), 19'h05000);
        for (int c = 0; c < 8; c++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        checkOutput("overflow drained", 19'(bus.out_valid), 19'd0);

        $display("[TB] steady push/pop with wrap");
        for (int c = 0; c < 16; c++)
            applyStimulus(1'b0, c < 12, 16'h6000 + 16'(c), c >= 7, 1'b1);
        for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        checkOutput("steady drained", 19'(bus.out_valid), 19'd0);

        $display("[TB] classification");
        applyStimulus(1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'h7C00, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'h7E01, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'hFC00, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'h3C00, 1'b0, 1'b1);
        for (int c = 0; c < 5; c++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        checkOutput("neg zero flags", 19'(bus.out_flags), CLS_EN ? 19'd1 : 19'd0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        checkOutput("inf flags", 19'(bus.out_flags), CLS_EN ? 19'd2 : 19'd0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        checkOutput("nan flags", 19'(bus.out_flags), CLS_EN ? 19'd4 : 19'd0);
        checkOutput("nan data", 19'(bus.out_data), 19'h07E01);
        for (int c = 0; c < 5; c++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);

        $display("[TB] reset mid-stream");
        applyStimulus(1'b0, 1'b1, 16'h1111, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'h2222, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'h3333, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'h4444, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'h5555, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        checkOutput("post-reset out_valid", 19'(bus.out_valid), 19'd0);
        checkOutput("post-reset issue_ready", 19'(bus.issue_ready), 19'd1);
        checkOutput("post-reset drop_err", 19'(bus.drop_err), 19'd0);
        for (int c = 0; c < 8; c++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        checkOutput("no stale result", 19'(bus.out_valid), 19'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
